// File: rtl/pcs_gearbox_tx_pkg.sv
// Shared 64b/66b PCS types and constants for the TX/RX gearboxes.
// Block layout puts the sync header in the LSBs so the header goes out on the wire first.
package pcs_gearbox_tx_pkg;
   localparam int HEAD_W = 2;
   localparam int DATA_W = 64;
   localparam int BLK_W  = HEAD_W + DATA_W;
   localparam int SEQ_N  = DATA_W / HEAD_W + 1;
   localparam int SEQ_W  = 6;
   localparam int SH_W   = 7;

   localparam logic [HEAD_W-1:0] SYNC_DATA = 2'b01;
   localparam logic [HEAD_W-1:0] SYNC_CTRL = 2'b10;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [HEAD_W-1:0] head;
   } blk_t;

   function automatic logic [SH_W-1:0] shamt(input logic [SEQ_W-1:0] seq);
      return {seq, 1'b0};
   endfunction
endpackage

// File: rtl/pcs_gearbox_tx_shift.sv
// Barrel merge of a 66-bit block over a right-justified residual by a bit-shift amount.
// Combinational, zero latency; no flow control.
// Emits the low 64 merged bits as the word and the spilled block bits as the next residual.
module pcs_gearbox_tx_shift
   import pcs_gearbox_tx_pkg::*;
(
   input  logic [BLK_W-1:0]  i_blk,
   input  logic [DATA_W-1:0] i_res,
   input  logic [SH_W-1:0]   i_sh,
   output logic [DATA_W-1:0] o_word,
   output logic [DATA_W-1:0] o_res
);
   logic [2*DATA_W-1:0] w_cat;
   logic [DATA_W-1:0]   w_mask;

   // Residual bits above the shift point are stale after a flush, so mask them off.
   assign w_mask = ~({DATA_W{1'b1}} << i_sh);
   assign w_cat  = ({{(2*DATA_W-BLK_W){1'b0}}, i_blk} << i_sh)
                 | {{DATA_W{1'b0}}, i_res & w_mask};

   assign o_word = w_cat[DATA_W-1:0];
   assign o_res  = w_cat[2*DATA_W-1:DATA_W];
endmodule

// File: rtl/pcs_gearbox_tx.sv
// TX 64b/66b gearbox: 32 blocks in, 33 SERDES words out, header first. Optional PCS_TX_UNDERRUN_CNT_EN.
// Latency: one cycle from acceptance to data_o/valid_o.
// Backpressure: ready_o drops for the single flush cycle of every 33; stalls emit no word.
module pcs_gearbox_tx
   import pcs_gearbox_tx_pkg::*;
(
   input  logic              clk,
   input  logic              nreset,
   input  logic              valid_i,
   input  logic [HEAD_W-1:0] head_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              ready_o,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o
`ifdef PCS_TX_UNDERRUN_CNT_EN
   ,
   output logic [7:0]        underrun_cnt_o
`endif
);
   localparam logic [SEQ_W-1:0] SEQ_LAST = SEQ_W'(SEQ_N - 1);

   logic [SEQ_W-1:0]  r_seq;
   logic [DATA_W-1:0] r_res;
   logic [DATA_W-1:0] r_data;
   logic              r_vld;

   blk_t              w_blk;
   logic [DATA_W-1:0] w_word;
   logic [DATA_W-1:0] w_res;

   assign w_blk   = '{data: data_i, head: head_i};
   assign ready_o = (r_seq != SEQ_LAST);
   assign valid_o = r_vld;
   assign data_o  = r_data;

   pcs_gearbox_tx_shift u_shift (
      .i_blk  (w_blk),
      .i_res  (r_res),
      .i_sh   (shamt(r_seq)),
      .o_word (w_word),
      .o_res  (w_res)
   );

   always_ff @(posedge clk) begin
      if (!nreset) begin
         r_seq  <= '0;
         r_res  <= '0;
         r_data <= '0;
         r_vld  <= 1'b0;
      end else if (!ready_o) begin
         // Residual is a full word: drain it regardless of valid_i.
         r_data <= r_res;
         r_vld  <= 1'b1;
         r_seq  <= '0;
      end else if (valid_i) begin
         r_data <= w_word;
         r_res  <= w_res;
         r_seq  <= r_seq + 1'b1;
         r_vld  <= 1'b1;
      end else begin
         r_vld  <= 1'b0;
      end
   end

`ifdef PCS_TX_UNDERRUN_CNT_EN
   logic [7:0] r_ucnt;

   always_ff @(posedge clk) begin
      if (!nreset) begin
         r_ucnt <= '0;
      end else if (ready_o && !valid_i && r_ucnt != 8'hFF) begin
         r_ucnt <= r_ucnt + 1'b1;
      end
   end

   assign underrun_cnt_o = r_ucnt;
`endif

`ifdef FORMAL
   always @(posedge clk) begin
      if (nreset) begin
         assert (r_seq < SEQ_W'(SEQ_N));
         assert (ready_o || r_seq == SEQ_LAST);
      end
   end
`endif
endmodule

// File: tb/tb_pcs_gearbox_tx.sv
// Bench for pcs_gearbox_tx: accepted blocks are pushed bit-by-bit into a serial queue and each
// valid output word is popped 64 bits LSB-first and compared.
module tb_pcs_gearbox_tx;
   import pcs_gearbox_tx_pkg::*;

   logic        clk = 1'b0;
   logic        nreset;
   logic        valid_i;
   logic [1:0]  head_i;
   logic [63:0] data_i;
   logic        ready_o;
   logic        valid_o;
   logic [63:0] data_o;
`ifdef PCS_TX_UNDERRUN_CNT_EN
   logic [7:0]  underrun_cnt_o;
`endif

   pcs_gearbox_tx dut (
      .clk     (clk),
      .nreset  (nreset),
      .valid_i (valid_i),
      .head_i  (head_i),
      .data_i  (data_i),
      .ready_o (ready_o),
      .valid_o (valid_o),
      .data_o  (data_o)
`ifdef PCS_TX_UNDERRUN_CNT_EN
      ,
      .underrun_cnt_o (underrun_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   bit          q[$];
   logic        exp_vld = 1'b0;
   logic [63:0] last_word = '0;
   int          acc_cnt = 0;
   int          low_cnt = 0;
   bit          count_low = 0;
   int          ucnt = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: check outputs of the previous edge, then drive this cycle's inputs.
   task automatic step(input logic v, input logic [1:0] h, input logic [63:0] d, input logic rst);
      logic [63:0] w;
      logic [65:0] blk;
      bit          full;
      @(negedge clk);
      chk("valid_o", valid_o, exp_vld);
      if (exp_vld) begin
         if (q.size() < 64) begin
            chk("underflow", 64'(q.size()), 64);
            q.delete();
         end else begin
            for (int i = 0; i < 64; i++) w[i] = q.pop_front();
            last_word = w;
         end
      end
      chk("data_o", data_o, last_word);
`ifdef PCS_TX_UNDERRUN_CNT_EN
      chk("underrun_cnt", 64'(underrun_cnt_o), 64'(ucnt));
`endif
      full = (q.size() == 64);
      chk("ready_o", ready_o, !full);
      if (count_low && ready_o === 1'b0) low_cnt++;
      nreset  = !rst;
      valid_i = v;
      head_i  = h;
      data_i  = d;
      if (rst) begin
         q.delete();
         exp_vld   = 1'b0;
         last_word = '0;
         ucnt      = 0;
      end else begin
         exp_vld = full || v;
         if (!full && v) begin
            blk = {d, h};
            for (int i = 0; i < 66; i++) q.push_back(blk[i]);
            acc_cnt++;
         end
         if (!full && !v && ucnt < 255) ucnt++;
      end
   endtask

   logic [63:0] hold_word;
   logic [1:0]  hb;
   logic [63:0] db;

   initial begin
      nreset  = 1'b0;
      valid_i = 1'b0;
      head_i  = 2'b00;
      data_i  = '0;

      step(0, 2'b00, 64'd0, 1);
      step(0, 2'b00, 64'd0, 1);
      step(0, 2'b00, 64'd0, 0);
      chk("rst_valid", valid_o, 1'b0);
      chk("rst_data", data_o, 64'd0);
      chk("rst_ready", ready_o, 1'b1);

      // Continuous data blocks: ready low on cycles 32, 65, 98.
      for (int cyc = 0; cyc < 99; cyc++) begin
         step(1, SYNC_DATA, 64'(cyc), 0);
         chk("ready_pattern", ready_o, 1'((cyc % 33) != 32));
         if (cyc >= 1) chk("valid_stream", valid_o, 1'b1);
      end

      // Single all-ones control block at seq 0, then a zero block exposes residual 2'b11.
      step(0, 2'b00, 64'd0, 1);
      step(1, SYNC_CTRL, 64'hFFFF_FFFF_FFFF_FFFF, 0);
      step(1, 2'b00, 64'd0, 0);
      chk("ctrl_word", data_o, 64'hFFFF_FFFF_FFFF_FFFE);
      step(0, 2'b00, 64'd0, 0);
      chk("residual_11", data_o, 64'h0000_0000_0000_0003);

      // Stall three cycles at seq 5, then resume to the end of the period.
      step(0, 2'b00, 64'd0, 1);
      for (int i = 0; i < 5; i++) step(1, SYNC_DATA, 64'hA5A5_0000_0000_0000 | 64'(i), 0);
      step(0, 2'b00, 64'd0, 0);
      hold_word = last_word;
      for (int i = 0; i < 3; i++) begin
         step(0, 2'b00, 64'd0, 0);
         chk("stall_valid", valid_o, 1'b0);
         chk("stall_hold", data_o, hold_word);
         chk("stall_ready", ready_o, 1'b1);
      end
      for (int i = 5; i < 32; i++) step(1, SYNC_CTRL, {$urandom, $urandom}, 0);
      step(0, 2'b00, 64'd0, 0);
      chk("stall_flush_ready", ready_o, 1'b0);

      // Reset mid-period at seq 17, then restart.
      for (int i = 0; i < 17; i++) step(1, SYNC_DATA, {$urandom, $urandom}, 0);
      step(1, SYNC_DATA, {$urandom, $urandom}, 1);
      hb = SYNC_CTRL;
      db = 64'h0123_4567_89AB_CDEF;
      step(1, hb, db, 0);
      chk("midrst_valid", valid_o, 1'b0);
      chk("midrst_data", data_o, 64'd0);
      step(0, 2'b00, 64'd0, 0);
      chk("post_rst_word", data_o, {db[61:0], hb});

      // 2112 random blocks, every header value included.
      step(0, 2'b00, 64'd0, 1);
      acc_cnt   = 0;
      low_cnt   = 0;
      count_low = 1;
      while (acc_cnt < 2112) step(1, 2'($urandom_range(0, 3)), {$urandom, $urandom}, 0);
      step(0, 2'b00, 64'd0, 0);
      step(0, 2'b00, 64'd0, 0);
      count_low = 0;
      chk("ready_low_cnt", 64'(low_cnt), 64'd66);
      chk("bits_drained", 64'(q.size()), 64'd0);

`ifdef PCS_TX_UNDERRUN_CNT_EN
      step(0, 2'b00, 64'd0, 1);
      for (int i = 0; i < 300; i++) step(0, 2'b00, 64'd0, 0);
      step(0, 2'b00, 64'd0, 0);
      chk("underrun_sat", 64'(underrun_cnt_o), 64'd255);
      step(0, 2'b00, 64'd0, 1);
      step(1, SYNC_DATA, 64'd1, 0);
      chk("underrun_clr", 64'(underrun_cnt_o), 64'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
